// File: rtl/arp_query_arbiter.sv
// Round-robin arbiter funnelling per-port ARP queries to a single ARP cache, one query in flight.
// Optional WAIT timeout with stale-response discard is enabled by defining ARP_QUERY_ARB_TIMEOUT_EN.
module arp_query_arbiter #(
  parameter int unsigned PORTS          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PORTS-1:0]    port_req_valid,
  input  logic [PORTS*32-1:0] port_req_ip,
  output logic [PORTS-1:0]    port_req_ready,
  output logic [PORTS-1:0]    port_resp_valid,
  input  logic [PORTS-1:0]    port_resp_ready,
  output logic               port_resp_error,
  output logic [47:0]         port_resp_mac,
  output logic               cache_req_valid,
  input  logic               cache_req_ready,
  output logic [31:0]         cache_req_ip,
  input  logic               cache_resp_valid,
  output logic               cache_resp_ready,
  input  logic               cache_resp_error,
  input  logic [47:0]         cache_resp_mac,
  output logic               busy
);

  localparam int unsigned GW = (PORTS > 1) ? $clog2(PORTS) : 1;

  if (PORTS < 2 || PORTS > 8 || TIMEOUT_CYCLES == 0) begin : g_param_check
    $error("arp_query_arbiter: PORTS must be 2..8 and TIMEOUT_CYCLES nonzero");
  end

  typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

  state_e          state_q;
  logic [GW-1:0]   grant_q;
  logic [GW-1:0]   last_q;
  logic [31:0]     ip_q;
  logic            err_q;
  logic [47:0]     mac_q;
  logic            stale;

`ifdef ARP_QUERY_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q;
  logic          stale_q;
  assign stale = stale_q;
`else
  assign stale = 1'b0;
`endif

  logic          sel_found;
  logic [GW-1:0] sel_idx;
  logic [GW-1:0] sel_p;
  logic [31:0]   sel_ip;
  logic          grant_en;
  logic          resp_ack;

  // Search upward from the port after the last grant, wrapping.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_p     = '0;
    for (int k = 1; k <= int'(PORTS); k++) begin
      sel_p = GW'((int'(last_q) + k) % int'(PORTS));
      if (!sel_found && port_req_valid[sel_p]) begin
        sel_found = 1'b1;
        sel_idx   = sel_p;
      end
    end
  end

  always_comb begin
    sel_ip = '0;
    for (int k = 0; k < int'(PORTS); k++) begin
      if (sel_idx == GW'(k)) sel_ip = port_req_ip[k*32 +: 32];
    end
  end

  // rst_n gating keeps the combinational ready low while reset is held.
  assign grant_en = rst_n && (state_q == StIdle) && sel_found && !stale;
  assign resp_ack = (state_q == StResp) && port_resp_ready[grant_q];

  always_comb begin
    port_req_ready = '0;
    if (grant_en) port_req_ready[sel_idx] = 1'b1;
  end

  always_comb begin
    port_resp_valid = '0;
    if (state_q == StResp) port_resp_valid[grant_q] = 1'b1;
  end

  assign busy             = (state_q != StIdle);
  assign cache_req_valid  = (state_q == StReq);
  assign cache_req_ip     = (state_q == StReq) ? ip_q : 32'h0;
  assign cache_resp_ready = (state_q == StWait) || stale;
  assign port_resp_error  = (state_q == StResp) && err_q;
  assign port_resp_mac    = (state_q == StResp) ? mac_q : 48'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      grant_q <= '0;
      last_q  <= GW'(PORTS - 1);
      ip_q    <= '0;
      err_q   <= 1'b0;
      mac_q   <= '0;
`ifdef ARP_QUERY_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      stale_q <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant_en) begin
            ip_q    <= sel_ip;
            grant_q <= sel_idx;
            state_q <= StReq;
          end
        end
        StReq: begin
          if (cache_req_ready) begin
            state_q <= StWait;
`ifdef ARP_QUERY_ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end
        end
        StWait: begin
          if (cache_resp_valid) begin
            err_q   <= cache_resp_error;
            mac_q   <= cache_resp_mac;
            state_q <= StResp;
          end
`ifdef ARP_QUERY_ARB_TIMEOUT_EN
          else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            // The cache still owes us a response; remember to swallow it.
            err_q   <= 1'b1;
            mac_q   <= '0;
            stale_q <= 1'b1;
            state_q <= StResp;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        StResp: begin
          if (resp_ack) begin
            last_q  <= grant_q;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
`ifdef ARP_QUERY_ARB_TIMEOUT_EN
      if (stale_q && cache_resp_valid) stale_q <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_arp_query_arbiter.sv
// Self-checking bench for arp_query_arbiter: grant table, directed corner cases and randomized
// transactions checked against a transaction-level round-robin model.
module tb_arp_query_arbiter;

  localparam int P = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [P-1:0]   port_req_valid = '0;
  logic [P*32-1:0] port_req_ip = '0;
  logic [P-1:0]   port_req_ready;
  logic [P-1:0]   port_resp_valid;
  logic [P-1:0]   port_resp_ready = '0;
  logic           port_resp_error;
  logic [47:0]    port_resp_mac;
  logic           cache_req_valid;
  logic           cache_req_ready = 1'b0;
  logic [31:0]    cache_req_ip;
  logic           cache_resp_valid = 1'b0;
  logic           cache_resp_ready;
  logic           cache_resp_error = 1'b0;
  logic [47:0]    cache_resp_mac = '0;
  logic           busy;

  arp_query_arbiter #(
    .PORTS          (P),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .port_req_valid   (port_req_valid),
    .port_req_ip      (port_req_ip),
    .port_req_ready   (port_req_ready),
    .port_resp_valid  (port_resp_valid),
    .port_resp_ready  (port_resp_ready),
    .port_resp_error  (port_resp_error),
    .port_resp_mac    (port_resp_mac),
    .cache_req_valid  (cache_req_valid),
    .cache_req_ready  (cache_req_ready),
    .cache_req_ip     (cache_req_ip),
    .cache_resp_valid (cache_resp_valid),
    .cache_resp_ready (cache_resp_ready),
    .cache_resp_error (cache_resp_error),
    .cache_resp_mac   (cache_resp_mac),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model state: pending requests, their addresses and the last served port.
  logic [P-1:0] pend = '0;
  logic [31:0]  ips [P];
  int           last = P - 1;

  typedef struct {
    logic [P-1:0] valid;
    logic [P-1:0] ready;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [P-1:0] oh(input int g);
    oh = '0;
    if (g >= 0) oh = P'(1) << g;
  endfunction

  function automatic int pick();
    for (int k = 1; k <= P; k++) begin
      if (pend[(last + k) % P]) return (last + k) % P;
    end
    return -1;
  endfunction

  task automatic drive_ports();
    port_req_valid = pend;
    for (int p = 0; p < P; p++) port_req_ip[p*32 +: 32] = ips[p];
  endtask

  task automatic chk_zero(input string n);
    chk({n, "_ctl"}, {busy, port_req_ready, port_resp_valid, cache_req_valid, cache_resp_ready,
                      port_resp_error}, 64'h0);
    chk({n, "_ip"}, cache_req_ip, 64'h0);
    chk({n, "_mac"}, port_resp_mac, 64'h0);
  endtask

  // One full query, called at a falling edge with the model's pending set prepared.
  task automatic txn(input int rs, input int rd, input int ad, input logic [47:0] mac,
                     input logic err, output int g);
    logic [31:0] ip;
    g = pick();
    drive_ports();
    cache_req_ready  = 1'b0;
    cache_resp_valid = 1'b0;
    port_resp_ready  = '0;
    #1;
    chk("grant", port_req_ready, oh(g));
    chk("idle_busy", busy, 0);
    if (g < 0) return;
    ip = ips[g];
    @(posedge clk);
    pend[g] = 1'b0;
    @(negedge clk);
    drive_ports();
    for (int i = 0; i <= rs; i++) begin
      cache_req_ready = (i == rs);
      #1;
      chk("cache_req", {busy, cache_req_valid, port_req_ready}, {1'b1, 1'b1, 4'b0});
      chk("cache_ip", cache_req_ip, ip);
      @(negedge clk);
    end
    cache_req_ready = 1'b0;
    for (int i = 0; i <= rd; i++) begin
      cache_resp_valid = (i == rd);
      cache_resp_mac   = (i == rd) ? mac : 48'h0;
      cache_resp_error = (i == rd) ? err : 1'b0;
      #1;
      chk("wait", {cache_resp_ready, cache_req_valid, port_resp_valid}, {1'b1, 1'b0, 4'b0});
      @(negedge clk);
    end
    cache_resp_valid = 1'b0;
    cache_resp_mac   = {16'($urandom), $urandom};
    cache_resp_error = 1'b1;
    for (int i = 0; i <= ad; i++) begin
      port_resp_ready = (i == ad) ? oh(g) : ~oh(g);
      #1;
      chk("resp_valid", {port_resp_valid, port_req_ready, cache_resp_ready},
          {oh(g), 4'b0, 1'b0});
      chk("resp_payload", {port_resp_error, port_resp_mac}, {err, mac});
      @(negedge clk);
    end
    port_resp_ready = '0;
    last = g;
  endtask

  initial begin
    vec_t tbl [7];
    int   order [5];
    int   g;
    int   g0;

    tbl[0] = '{valid: 4'b0000, ready: 4'b0000};
    tbl[1] = '{valid: 4'b0001, ready: 4'b0001};
    tbl[2] = '{valid: 4'b0110, ready: 4'b0010};
    tbl[3] = '{valid: 4'b1000, ready: 4'b1000};
    tbl[4] = '{valid: 4'b1100, ready: 4'b0100};
    tbl[5] = '{valid: 4'b1111, ready: 4'b0001};
    tbl[6] = '{valid: 4'b1010, ready: 4'b0010};
    order  = '{0, 1, 3, 0, 1};
    for (int p = 0; p < P; p++) ips[p] = 32'h0;

    // Reset with requests already asserted.
    port_req_valid = '1;
    repeat (2) @(negedge clk);
    #1;
    chk_zero("in_reset");
    port_req_valid = '0;
    rst_n = 1'b1;
    #1;
    chk_zero("post_reset");

    // Combinational grant selection in IDLE, last grant = 3 after reset.
    foreach (tbl[i]) begin
      @(negedge clk);
      port_req_valid = tbl[i].valid;
      #1;
      chk($sformatf("tbl%0d_ready", i), port_req_ready, tbl[i].ready);
      chk($sformatf("tbl%0d_busy", i), {busy, port_resp_valid}, 0);
      port_req_valid = '0;
    end
    @(negedge clk);

    // Ports 0,1,3 requesting continuously.
    for (int i = 0; i < 5; i++) begin
      pend = 4'b1011;
      for (int p = 0; p < P; p++) ips[p] = 32'h0A000000 + 32'(p);
      txn(0, 0, 0, {16'h1000, 32'(i)}, 1'b0, g);
      chk($sformatf("order%0d", i), g, order[i]);
    end

    // Single port 2 query, zero-wait cache.
    pend = 4'b0100;
    ips[2] = 32'hC0A80102;
    txn(0, 0, 0, 48'h0200DEADBEEF, 1'b0, g);
    chk("single_p2", g, 2);

    // Cache stalls request acceptance, then requester stalls the response.
    pend = 4'b1111;
    for (int p = 0; p < P; p++) ips[p] = $urandom;
    txn(5, 0, 0, 48'h0000AABBCCDD, 1'b1, g);
    txn(0, 1, 4, 48'h123456789ABC, 1'b0, g);

`ifndef ARP_QUERY_ARB_TIMEOUT_EN
    // Without the timeout the arbiter waits for a slow cache.
    if (pend == '0) pend[0] = 1'b1;
    txn(0, 20, 0, 48'h5A5A5A5A5A5A, 1'b0, g);
`endif

    for (int t = 0; t < 40; t++) begin
      for (int p = 0; p < P; p++) begin
        if (!pend[p] && $urandom_range(0, 1) == 1) begin
          pend[p] = 1'b1;
          ips[p]  = $urandom;
        end
      end
      if (pend == '0) begin
        g0 = $urandom_range(0, P - 1);
        pend[g0] = 1'b1;
        ips[g0]  = $urandom;
      end
      txn($urandom_range(0, 4), $urandom_range(0, 5), $urandom_range(0, 3),
          {16'($urandom), $urandom}, 1'($urandom), g);
    end

`ifdef ARP_QUERY_ARB_TIMEOUT_EN
    // Silent cache: forced error response, then grants blocked until the late response.
    pend = 4'b0100;
    ips[2] = 32'h0A0B0C0D;
    drive_ports();
    g0 = pick();
    @(posedge clk);
    pend[g0] = 1'b0;
    @(negedge clk);
    drive_ports();
    cache_req_ready = 1'b1;
    @(negedge clk);
    cache_req_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("to_wait", {cache_resp_ready, port_resp_valid}, {1'b1, 4'b0});
      @(negedge clk);
    end
    #1;
    chk("to_resp", port_resp_valid, oh(g0));
    chk("to_payload", {port_resp_error, port_resp_mac}, {1'b1, 48'h0});
    port_resp_ready = oh(g0);
    @(negedge clk);
    port_resp_ready = '0;
    last = g0;
    pend = 4'b0001;
    drive_ports();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stale_block", {port_req_ready, cache_resp_ready, busy}, {4'b0, 1'b1, 1'b0});
      @(negedge clk);
    end
    cache_resp_valid = 1'b1;
    cache_resp_mac   = 48'hFFFF00001111;
    #1;
    chk("stale_late", port_req_ready, 0);
    @(negedge clk);
    cache_resp_valid = 1'b0;
    #1;
    chk("stale_clear", {port_req_ready, port_resp_valid, cache_resp_ready},
        {oh(pick()), 4'b0, 1'b0});
    txn(0, 0, 0, 48'h00000000BEEF, 1'b0, g);
`endif

    // Reset while waiting on the cache abandons the query.
    pend = '1;
    for (int p = 0; p < P; p++) ips[p] = $urandom;
    drive_ports();
    g0 = pick();
    @(posedge clk);
    @(negedge clk);
    cache_req_ready = 1'b1;
    @(negedge clk);
    cache_req_ready = 1'b0;
    #1;
    chk("pre_rst_wait", {busy, cache_resp_ready}, 2'b11);
    rst_n = 1'b0;
    #1;
    chk_zero("mid_rst");
    @(negedge clk);
    #1;
    chk_zero("mid_rst_held");
    rst_n = 1'b1;
    last = P - 1;
    pend = '1;
    #1;
    chk("no_resp_after_rst", port_resp_valid, 0);
    txn(0, 0, 0, 48'h0000C0FFEE00, 1'b0, g);
    chk("first_after_rst", g, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
